// File: rtl/av_sata_link_rate_ctrl_pkg.sv
// Shared state encoding, generation codes and generation-step helpers
// for the SATA link-rate controller.
package av_sata_link_rate_ctrl_pkg;
`include "sata_defs.svh"

  localparam logic [1:0] SATA_GEN1 = `SATA_GEN1;
  localparam logic [1:0] SATA_GEN2 = `SATA_GEN2;
  localparam logic [1:0] SATA_GEN3 = `SATA_GEN3;

  typedef enum logic [2:0] {
    st_idle,
    st_reconf_req,
    st_reconf_wait,
    st_xcvr_rst,
    st_xcvr_wait,
    st_link_wait,
    st_linked,
    st_failed
  } state_t;

  function automatic logic [1:0] sata_gen_step_down(input logic [1:0] gen);
    case (gen)
      SATA_GEN3: return SATA_GEN2;
      SATA_GEN2: return SATA_GEN1;
      default:   return SATA_GEN1;
    endcase
  endfunction

  // Unknown codes are treated as the slowest generation.
  function automatic logic [1:0] sata_gen_sanitize(input logic [1:0] gen);
    case (gen)
      SATA_GEN3: return SATA_GEN3;
      SATA_GEN2: return SATA_GEN2;
      default:   return SATA_GEN1;
    endcase
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sata_defs.svh
// SATA generation codes as presented to the transceiver reconfiguration engine.
`ifndef SATA_DEFS_SVH
`define SATA_DEFS_SVH
`define SATA_GEN1 2'd0
`define SATA_GEN2 2'd1
`define SATA_GEN3 2'd2
`endif

// File: rtl/sata_pulse_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
// Latency: a load of N gives N further cycles before done. No backpressure.
module sata_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/av_sata_link_rate_ctrl.sv
// SATA link-rate negotiation: reconfigure, reset transceiver, time link-up, step GEN3->GEN2->GEN1.
// Latency: outputs registered from next state; cmd_ready rise in reconf_wait -> xcvr_reset in 1 clk.
// Backpressure: cmd_reconfig held until cmd_ready; SATA_RATE_CTRL_WRAP_EN restarts the sweep at GEN1 exhaustion.
module av_sata_link_rate_ctrl
  import av_sata_link_rate_ctrl_pkg::*;
#(
  parameter int ATTEMPTS     = 3,
  parameter int LINK_TIMEOUT = 2500000,
  parameter int RST_CYCLES   = 16
) (
  input  logic       reset,
  input  logic       clk,
  input  logic       enable,
  input  logic [1:0] max_gen,
  output logic       cmd_reconfig,
  output logic [1:0] cmd_sata_gen,
  input  logic       cmd_ready,
  output logic       xcvr_reset,
  input  logic       xcvr_ready,
  output logic       phy_rst,
  input  logic       phy_linkup,
  input  logic       phy_fail,
  output logic [1:0] cur_gen,
  output logic       linked,
  output logic       failed
);
  localparam int TW = cnt_w(LINK_TIMEOUT);
  localparam int RW = cnt_w(RST_CYCLES);
  localparam int AW = $clog2(ATTEMPTS + 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(LINK_TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);
  localparam logic [AW-1:0] ATT_LAST = AW'(ATTEMPTS - 1);

  state_t          state, state_nx;
  logic [1:0]      cur_gen_nx, max_gen_q, max_gen_nx;
  logic [AW-1:0]   att, att_nx;
  logic            hold_q;
  logic            rst_done, to_done;
  logic            rst_load, to_load;

  always_comb begin
    state_nx   = state;
    cur_gen_nx = cur_gen;
    max_gen_nx = max_gen_q;
    att_nx     = att;
    case (state)
      st_idle: if (enable) begin
        max_gen_nx = sata_gen_sanitize(max_gen);
        cur_gen_nx = sata_gen_sanitize(max_gen);
        att_nx     = '0;
        state_nx   = st_reconf_req;
      end
      // An offered command that the engine takes is never dropped by enable.
      st_reconf_req:
        if (cmd_ready)    state_nx = st_reconf_wait;
        else if (!enable) state_nx = st_idle;
      st_reconf_wait:
        if (hold_q && cmd_ready) state_nx = enable ? st_xcvr_rst : st_idle;
      st_xcvr_rst:
        if (!enable)       state_nx = st_idle;
        else if (rst_done) state_nx = st_xcvr_wait;
      st_xcvr_wait:
        if (!enable)         state_nx = st_idle;
        else if (xcvr_ready) state_nx = st_link_wait;
      st_link_wait: begin
        if (!enable)
          state_nx = st_idle;
        else if (phy_linkup)
          state_nx = st_linked;
        else if (phy_fail || to_done) begin
          if (att != ATT_LAST) begin
            att_nx   = att + 1'b1;
            state_nx = st_xcvr_rst;
          end else if (cur_gen != SATA_GEN1) begin
            cur_gen_nx = sata_gen_step_down(cur_gen);
            att_nx     = '0;
            state_nx   = st_reconf_req;
          end else begin
`ifdef SATA_RATE_CTRL_WRAP_EN
            cur_gen_nx = max_gen_q;
            att_nx     = '0;
            state_nx   = st_reconf_req;
`else
            state_nx   = st_failed;
`endif
          end
        end
      end
      st_linked:
        if (!enable)
          state_nx = st_idle;
        else if (!phy_linkup) begin
          cur_gen_nx = max_gen_q;
          att_nx     = '0;
          state_nx   = st_reconf_req;
        end
      st_failed:
        if (!enable) state_nx = st_idle;
      default: state_nx = st_idle;
    endcase
  end

  assign rst_load = (state_nx == st_xcvr_rst)  && (state != st_xcvr_rst);
  assign to_load  = (state_nx == st_link_wait) && (state != st_link_wait);

  sata_pulse_timer #(.W(RW)) u_rst_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (rst_load),
    .load_val (RST_LOAD),
    .done     (rst_done)
  );

  sata_pulse_timer #(.W(TW)) u_link_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (to_load),
    .load_val (TO_LOAD),
    .done     (to_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= st_idle;
      cur_gen      <= SATA_GEN3;
      max_gen_q    <= SATA_GEN3;
      att          <= '0;
      hold_q       <= 1'b0;
      cmd_reconfig <= 1'b0;
      xcvr_reset   <= 1'b0;
      phy_rst      <= 1'b1;
      linked       <= 1'b0;
      failed       <= 1'b0;
    end else begin
      state        <= state_nx;
      cur_gen      <= cur_gen_nx;
      max_gen_q    <= max_gen_nx;
      att          <= att_nx;
      // cmd_ready may still read high for one cycle after acceptance.
      hold_q       <= (state == st_reconf_wait) && (state_nx == st_reconf_wait);
      cmd_reconfig <= (state_nx == st_reconf_req);
      xcvr_reset   <= (state_nx == st_xcvr_rst);
      phy_rst      <= !((state_nx == st_link_wait) || (state_nx == st_linked));
      linked       <= (state_nx == st_linked);
      failed       <= (state_nx == st_failed);
    end
  end

  assign cmd_sata_gen = cur_gen;
endmodule

// File: tb/tb_av_sata_link_rate_ctrl.sv
// Randomized scoreboard bench for av_sata_link_rate_ctrl; honours SATA_RATE_CTRL_WRAP_EN.
module tb_av_sata_link_rate_ctrl;
  import av_sata_link_rate_ctrl_pkg::*;

  localparam int ATT = 3, LT = 200, RSTC = 16;
  localparam int EV_CMD = 1, EV_PULSE = 2, EV_WIN = 3, EV_LINK = 4, EV_FAILED = 5;
  localparam int K_LINK = 0, K_FAIL = 1, K_TMO = 2, K_LINKFAIL = 3;

  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [1:0] max_gen = SATA_GEN3;
  logic       cmd_ready = 1'b1, xcvr_ready = 1'b1, phy_linkup = 1'b0, phy_fail = 1'b0;
  logic       cmd_reconfig, xcvr_reset, phy_rst, linked, failed;
  logic [1:0] cmd_sata_gen, cur_gen;

  typedef struct { int kind; int val; } ev_t;
  ev_t exp_q[$];
  int  plan[$];
  int  phy_q[$];
  int  compared = 0, mismatched = 0;
  bit  drop_link = 1'b0;

  always #5 clk = ~clk;

  av_sata_link_rate_ctrl #(.ATTEMPTS(ATT), .LINK_TIMEOUT(LT), .RST_CYCLES(RSTC)) dut (
    .reset(reset), .clk(clk), .enable(enable), .max_gen(max_gen),
    .cmd_reconfig(cmd_reconfig), .cmd_sata_gen(cmd_sata_gen), .cmd_ready(cmd_ready),
    .xcvr_reset(xcvr_reset), .xcvr_ready(xcvr_ready), .phy_rst(phy_rst),
    .phy_linkup(phy_linkup), .phy_fail(phy_fail), .cur_gen(cur_gen),
    .linked(linked), .failed(failed)
  );

  function automatic logic [1:0] ref_down(input logic [1:0] g);
    if (g == SATA_GEN3) return SATA_GEN2;
    return SATA_GEN1;
  endfunction

  function automatic logic [1:0] ref_clamp(input logic [1:0] g);
    if (g == SATA_GEN3 || g == SATA_GEN2) return g;
    return SATA_GEN1;
  endfunction

  task automatic push_ev(input int k, input int v);
    ev_t e;
    e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  // Expected event stream for one negotiation consuming the planned attempt outcomes.
  task automatic model(input logic [1:0] gen_start, input logic [1:0] maxg);
    logic [1:0] g;
    int att, o, kind;
    g = gen_start; att = 0;
    push_ev(EV_CMD, int'(g)); push_ev(EV_PULSE, RSTC);
    while (plan.size() > 0) begin
      o = plan.pop_front(); phy_q.push_back(o); kind = o / 100;
      if (kind == K_LINK || kind == K_LINKFAIL) begin
        push_ev(EV_LINK, int'(g));
        return;
      end
      push_ev(EV_WIN, (kind == K_TMO) ? LT : (o % 100) + 1);
      att++;
      if (att < ATT) push_ev(EV_PULSE, RSTC);
      else begin
        att = 0;
        if (g != SATA_GEN1) begin
          g = ref_down(g);
          push_ev(EV_CMD, int'(g)); push_ev(EV_PULSE, RSTC);
        end else begin
`ifdef SATA_RATE_CTRL_WRAP_EN
          g = maxg;
          push_ev(EV_CMD, int'(g)); push_ev(EV_PULSE, RSTC);
`else
          push_ev(EV_FAILED, 0);
          return;
`endif
        end
      end
    end
  endtask

  task automatic check(input string nm, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic got(input int k, input int v);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_event: kind %0d val %0d, expected none at %0t", k, v, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        mismatched++;
        $display("FAIL event: got kind %0d val %0d, expected kind %0d val %0d at %0t",
                 k, v, e.kind, e.val, $time);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk); n++;
    end
    #1;
    compared++;
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain_timeout: %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic end_scenario();
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_phy_rst", phy_rst, 1);
    check("idle_linked", linked, 0);
    check("idle_failed", failed, 0);
    check("idle_cmd_reconfig", cmd_reconfig, 0);
    check("idle_xcvr_reset", xcvr_reset, 0);
  endtask

  // Reconfiguration engine: cmd_ready falls (registered) after acceptance, busy a few cycles.
  initial begin
    int busy = 0;
    bit acc;
    forever begin
      @(posedge clk);
      acc = cmd_reconfig && cmd_ready;
      #1;
      if (reset) begin cmd_ready = 1'b1; busy = 0; end
      else if (acc) begin cmd_ready = 1'b0; busy = int'($urandom_range(1, 8)); end
      else if (!cmd_ready) begin busy--; if (busy <= 0) cmd_ready = 1'b1; end
    end
  end

  // Transceiver: ready drops during reset pulse, returns a few cycles later.
  initial begin
    int xd = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) xcvr_ready = 1'b1;
      else if (xcvr_reset) begin xcvr_ready = 1'b0; xd = int'($urandom_range(1, 5)); end
      else if (!xcvr_ready) begin xd--; if (xd <= 0) xcvr_ready = 1'b1; end
    end
  end

  // PHY responder: one planned outcome per phy_rst-low window.
  initial begin
    int cur = -1, cnt = 0, k;
    bit active = 1'b0, acted = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (reset || phy_rst) begin
        active = 1'b0; phy_linkup = 1'b0; phy_fail = 1'b0;
      end else begin
        phy_fail = 1'b0;
        if (drop_link) phy_linkup = 1'b0;
        if (!active) begin
          active = 1'b1; cnt = 0; acted = 1'b0;
          cur = (phy_q.size() > 0) ? phy_q.pop_front() : -1;
        end else cnt++;
        if (cur >= 0 && !acted && cnt == cur % 100) begin
          acted = 1'b1; k = cur / 100;
          if (k == K_LINK || k == K_LINKFAIL) phy_linkup = 1'b1;
          if (k == K_FAIL || k == K_LINKFAIL) phy_fail = 1'b1;
        end
      end
    end
  end

  // Monitor: turns DUT output activity into events and checks them against the queue.
  initial begin
    int pw = 0, wl = 0;
    bit pr_x = 1'b0, pr_p = 1'b1, pr_l = 1'b0, pr_f = 1'b0, win_link = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pw = 0; wl = 0; win_link = 1'b0;
        pr_x = 1'b0; pr_p = 1'b1; pr_l = 1'b0; pr_f = 1'b0;
      end else begin
        if (xcvr_reset) pw++;
        else if (pr_x) begin got(EV_PULSE, pw); pw = 0; end
        if (!phy_rst) begin wl++; if (linked) win_link = 1'b1; end
        else if (!pr_p) begin
          if (!win_link && enable) got(EV_WIN, wl);
          wl = 0; win_link = 1'b0;
        end
        if (linked && !pr_l) got(EV_LINK, int'(cur_gen));
        if (failed && !pr_f) got(EV_FAILED, 0);
        if (cmd_reconfig && cmd_ready) got(EV_CMD, int'(cmd_sata_gen));
        pr_x = xcvr_reset; pr_p = phy_rst; pr_l = linked; pr_f = failed;
      end
    end
  end

  initial begin
    #800000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, r;
    logic [1:0] mg;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_reconfig", cmd_reconfig, 0);
    check("rst_cmd_sata_gen", cmd_sata_gen, SATA_GEN3);
    check("rst_cur_gen", cur_gen, SATA_GEN3);
    check("rst_xcvr_reset", xcvr_reset, 0);
    check("rst_phy_rst", phy_rst, 1);
    check("rst_linked", linked, 0);
    check("rst_failed", failed, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Link up at GEN3 on the first attempt.
    max_gen = SATA_GEN3;
    plan.push_back(K_LINK * 100 + 50);
    model(SATA_GEN3, SATA_GEN3);
    enable = 1'b1;
    wait_drain(2000);
    check("a_linked", linked, 1);
    check("a_cur_gen", cur_gen, SATA_GEN3);
    end_scenario();

    // Three timeouts at GEN3 then reconfiguration to GEN2.
    for (int i = 0; i < 3; i++) plan.push_back(K_TMO * 100);
    model(SATA_GEN3, SATA_GEN3);
    enable = 1'b1;
    wait_drain(5000);
    end_scenario();

    // Nine failures: exhaust all generations.
    for (int i = 0; i < 9; i++) plan.push_back(K_FAIL * 100 + int'($urandom_range(0, 30)));
    model(SATA_GEN3, SATA_GEN3);
    enable = 1'b1;
    wait_drain(8000);
`ifndef SATA_RATE_CTRL_WRAP_EN
    check("c_failed", failed, 1);
    check("c_failed_phy_rst", phy_rst, 1);
`endif
    end_scenario();

    // enable dropped while the engine is busy: reconfiguration completes, no xcvr_reset.
    max_gen = SATA_GEN2;
    push_ev(EV_CMD, int'(SATA_GEN2));
    enable = 1'b1;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (cmd_ready && n < 50);
    check("d_engine_busy", cmd_ready, 0);
    enable = 1'b0;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!cmd_ready && n < 50);
    check("d_engine_done", cmd_ready, 1);
    repeat (30) @(posedge clk);
    wait_drain(10);
    check("d_phy_rst", phy_rst, 1);
    check("d_xcvr_reset", xcvr_reset, 0);
    check("d_cmd_reconfig", cmd_reconfig, 0);

    // Linked at GEN2, link drops, renegotiation from GEN3 (linkup wins over fail).
    max_gen = SATA_GEN3;
    for (int i = 0; i < 3; i++) plan.push_back(K_FAIL * 100 + int'($urandom_range(0, 20)));
    plan.push_back(K_LINK * 100 + 7);
    model(SATA_GEN3, SATA_GEN3);
    enable = 1'b1;
    wait_drain(5000);
    check("e_linked", linked, 1);
    check("e_cur_gen_gen2", cur_gen, SATA_GEN2);
    plan.push_back(K_LINKFAIL * 100 + 10);
    model(SATA_GEN3, SATA_GEN3);
    drop_link = 1'b1;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!phy_rst && n < 20);
    drop_link = 1'b0;
    check("e_link_drop_phy_rst", phy_rst, 1);
    wait_drain(3000);
    check("e_relinked", linked, 1);
    check("e_cur_gen_gen3", cur_gen, SATA_GEN3);
    end_scenario();

    // Randomized negotiations.
    for (int round = 0; round < 6; round++) begin
      mg = 2'($urandom_range(0, 3));
      len = int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 2) begin plan.push_back(K_LINK * 100 + int'($urandom_range(0, 40))); break; end
        else if (r == 2) begin plan.push_back(K_LINKFAIL * 100 + int'($urandom_range(0, 40))); break; end
        else if (r == 3) plan.push_back(K_TMO * 100);
        else plan.push_back(K_FAIL * 100 + int'($urandom_range(0, 40)));
      end
      model(ref_clamp(mg), ref_clamp(mg));
      max_gen = mg;
      enable = 1'b1;
      wait_drain(20000);
      end_scenario();
    end

    // Asynchronous reset in the middle of the transceiver reset pulse.
    max_gen = SATA_GEN1;
    model(SATA_GEN1, SATA_GEN1);
    enable = 1'b1;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!xcvr_reset && n < 100);
    check("f_in_xcvr_rst", xcvr_reset, 1);
    check("f_cur_gen_gen1", cur_gen, SATA_GEN1);
    repeat (4) @(posedge clk);
    #3;
    exp_q.delete();
    reset = 1'b1;
    #1;
    check("f_rst_xcvr_reset", xcvr_reset, 0);
    check("f_rst_phy_rst", phy_rst, 1);
    check("f_rst_cur_gen", cur_gen, SATA_GEN3);
    check("f_rst_cmd_sata_gen", cmd_sata_gen, SATA_GEN3);
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
